// File: rtl/fir_axis_out_fifo.sv
// Output buffer behind the FIR stream master port.
// Register FIFO with first-word-fall-through AXI-Stream master side,
// occupancy reporting and a saturating completed-frame counter.
module fir_axis_out_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 16,
  parameter int unsigned pPTR_W      = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   clr,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [pPTR_W:0]        level,
  output logic                   full,
  output logic                   empty,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned LVL_W = pPTR_W + 1;
  localparam int unsigned ENT_W = pDATA_WIDTH + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(pDEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Storage: {tlast, tdata} per entry; contents are don't-care until written
  logic [ENT_W-1:0] mem [pDEPTH];

  logic              ready_en;
  logic [pPTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [pPTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  occ_e              occ_q, occ_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [ENT_W-1:0]  head_q, head_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              push_c;
  logic              pop_c;

  // Upstream ready depends only on state plus the clr override
  assign s_tready   = ready_en & ~full & ~clr;
  assign full       = (occ_q == OCC_FULL);
  assign empty      = (occ_q == OCC_EMPTY);
  assign level      = level_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = head_q[pDATA_WIDTH-1:0];
  assign m_tlast    = head_q[ENT_W-1];
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Ready enable: holds s_tready low until the first edge after reset release
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) ready_en <= 1'b0;
    else             ready_en <= 1'b1;
  end

  // Data RAM write; clr already blocks push via s_tready
  always_ff @(posedge axis_clk) begin
    if (push_c) mem[wr_ptr_q] <= {s_tlast, s_tdata};
  end

  // Next-state: pointers, level, occupancy, prefetched head beat, frame tracking
  always_comb begin
    push_c       = s_tvalid & s_tready;
    pop_c        = m_tvalid_q & m_tready;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    occ_d        = occ_q;
    m_tvalid_d   = 1'b0;
    head_d       = '0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      occ_d       = OCC_EMPTY;
      frame_cnt_d = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + pPTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + pPTR_W'(1);

      if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
      else if (pop_c && !push_c) level_d = level_q - LVL_W'(1);

      if (pop_c && head_q[ENT_W-1]) begin
        frame_done_d = 1'b1;
        if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
      end

      // Head of the next cycle: forward the beat being written if it lands there
      if (level_d != '0) begin
        m_tvalid_d = 1'b1;
        if (push_c && (rd_ptr_d == wr_ptr_q)) head_d = {s_tlast, s_tdata};
        else                                  head_d = mem[rd_ptr_d];
      end

      if (level_d == '0)           occ_d = OCC_EMPTY;
      else if (level_d == LVL_FULL) occ_d = OCC_FULL;
      else                          occ_d = OCC_PARTIAL;
    end
  end

  // State registers
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      occ_q        <= OCC_EMPTY;
      m_tvalid_q   <= 1'b0;
      head_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      occ_q        <= occ_d;
      m_tvalid_q   <= m_tvalid_d;
      head_q       <= head_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// Self-checking bench for fir_axis_out_fifo: directed steps, scoreboard queue,
// cycle-level occupancy/handshake model.
module tb_fir_axis_out_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [4:0]    level;
  logic          full;
  logic          empty;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  fir_axis_out_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pPTR_W(4)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .clr(clr),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .level(level), .full(full), .empty(empty),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  logic [32:0] sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int mlevel   = 0;
  int mfc      = 0;
  bit exp_fd   = 1'b0;
  bit rdy_en   = 1'b0;
  bit last_push = 1'b0;
  int pop_cnt  = 0;
  int max_lvl  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mlevel = 0;
    mfc    = 0;
    exp_fd = 1'b0;
    rdy_en = 1'b0;
  endtask

  // One clock: check outputs against model, score handshakes, advance model
  task automatic tick();
    bit er, push, pop, fd_n;
    logic [32:0] head;
    #1;
    er   = rdy_en && (mlevel < DEPTH) && !clr && axis_rst_n;
    push = s_tvalid && er;
    pop  = (mlevel != 0) && m_tready && axis_rst_n;
    fd_n = 1'b0;
    chk("s_tready",   64'(s_tready),   64'(er));
    chk("m_tvalid",   64'(m_tvalid),   64'(mlevel != 0));
    chk("level",      64'(level),      64'(mlevel));
    chk("full",       64'(full),       64'(mlevel == DEPTH));
    chk("empty",      64'(empty),      64'(mlevel == 0));
    chk("frame_done", 64'(frame_done), 64'(exp_fd));
    chk("frame_cnt",  64'(frame_cnt),  64'(mfc));
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (pop && sb.size() > 0) begin
      head = sb.pop_front();
      chk("m_beat", 64'({m_tlast, m_tdata}), 64'(head));
      fd_n = head[32];
      pop_cnt++;
    end
    last_push = push;
    @(posedge axis_clk);
    if (!axis_rst_n) begin
      model_reset();
    end else if (clr) begin
      sb.delete();
      mlevel = 0;
      mfc    = 0;
      exp_fd = 1'b0;
      rdy_en = 1'b1;
    end else begin
      if (push) sb.push_back({s_tlast, s_tdata});
      mlevel = mlevel + int'(push) - int'(pop);
      exp_fd = fd_n;
      if (fd_n && mfc != 16'hFFFF) mfc++;
      rdy_en = 1'b1;
    end
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    last_push = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_push) break;
    end
    chk("send_accepted", 64'(last_push), 64'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (mlevel == 0) break;
      tick();
    end
    tick();
    chk("drain_empty", 64'(empty), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // Reset values
    model_reset();
    tick();
    tick();
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    axis_rst_n = 1'b1;
    tick();
    tick();

    // 1: single beat, latency one cycle
    m_tready = 1'b1;
    send(32'h0000_0007, 1'b0);
    chk("t1_level1", 64'(level), 64'(1));
    chk("t1_data", 64'(m_tdata), 64'(7));
    tick();
    chk("t1_level0", 64'(level), 64'(0));

    // 2: fill past depth with consumer stalled
    m_tready = 1'b0;
    for (int i = 1; i <= 16; i++) send(32'(i), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd17;
    for (int k = 0; k < 3; k++) tick();
    chk("t2_full", 64'(full), 64'(1));
    chk("t2_level", 64'(level), 64'(16));
    m_tready = 1'b1;
    send(32'd17, 1'b0);
    drain();

    // 3: continuous streaming, one frame
    max_lvl = 0;
    p0 = pop_cnt;
    m_tready = 1'b1;
    for (int i = 0; i < 600; i++) send(32'(1000 + i), i == 599);
    drain();
    chk("t3_max_level", 64'(max_lvl <= 1), 64'(1));
    chk("t3_beats", 64'(pop_cnt - p0), 64'(600));
    chk("t3_frame_cnt", 64'(frame_cnt), 64'(1));

    // 4: pop and offered beat in the same cycle while full
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'(200 + i), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd99;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk("t4_level", 64'(level), 64'(15));
    chk("t4_ready", 64'(s_tready), 64'(1));
    tick();
    s_tvalid = 1'b0;
    drain();

    // 5: clr at level 5 with a beat offered
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'(300 + i), 1'b1);
    chk("t5_level5", 64'(level), 64'(5));
    clr      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'd55;
    tick();
    clr      = 1'b0;
    s_tvalid = 1'b0;
    chk("t5_level", 64'(level), 64'(0));
    chk("t5_empty", 64'(empty), 64'(1));
    chk("t5_mvalid", 64'(m_tvalid), 64'(0));
    chk("t5_fcnt", 64'(frame_cnt), 64'(0));
    m_tready = 1'b1;
    tick();
    tick();

    // 6: asynchronous reset mid-stream at level 8
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'(400 + i), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd77;
    #2;
    axis_rst_n = 1'b0;
    #1;
    chk("t6_mvalid", 64'(m_tvalid), 64'(0));
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_empty", 64'(empty), 64'(1));
    chk("t6_sready", 64'(s_tready), 64'(0));
    chk("t6_mdata", 64'(m_tdata), 64'(0));
    model_reset();
    @(posedge axis_clk);
    #1;
    tick();
    axis_rst_n = 1'b1;
    tick();
    tick();
    s_tvalid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
